// File: rtl/aurora_axis_tx_mux_pkg.sv
// aurora_axis_tx_mux_pkg: shared stream widths, selector width and FSM states for the Aurora TX mux
package aurora_axis_tx_mux_pkg;
    localparam int AXIS_DW = 32;
    localparam int AXIS_KW = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, PKT} state_t;
endpackage

// File: rtl/aurora_axis_tx_mux.sv
// aurora_axis_tx_mux: packet-atomic N:1 AXIS mux with registered master output; AURORA_TX_MUX_STAT_EN adds pkt_cnt
module aurora_axis_tx_mux
    import aurora_axis_tx_mux_pkg::*;
#(
    parameter int ETHCOUNT = 4,
    parameter int SIM = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SEL_W-1:0]             sel,
    output logic [ETHCOUNT-1:0]          axis_s_tready,
    input  logic [ETHCOUNT*AXIS_DW-1:0]  axis_s_tdata,
    input  logic [ETHCOUNT*AXIS_KW-1:0]  axis_s_tkeep,
    input  logic [ETHCOUNT-1:0]          axis_s_tvalid,
    input  logic [ETHCOUNT-1:0]          axis_s_tlast,
    input  logic                         axis_m_tready,
    output logic [AXIS_DW-1:0]           axis_m_tdata,
    output logic [AXIS_KW-1:0]           axis_m_tkeep,
    output logic                         axis_m_tvalid,
    output logic                         axis_m_tlast
`ifdef AURORA_TX_MUX_STAT_EN
    ,
    output logic [15:0]                  pkt_cnt
`endif
);
    localparam int NSRC = ETHCOUNT + (SIM & 0);
    state_t state, state_nx;
    logic [SEL_W-1:0] src_q, eff;
    logic can_load, acc, sel_last;
    logic [AXIS_DW-1:0] sel_data;
    logic [AXIS_KW-1:0] sel_keep;
    // Pick the effective source, gate its ready and decide the next state
    always_comb begin
        eff = (state == PKT) ? src_q : sel;
        can_load = (~axis_m_tvalid | axis_m_tready) & ~rst;
        axis_s_tready = '0;
        sel_data = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (eff == SEL_W'(i)) begin
                axis_s_tready[i] = can_load;
                sel_data = axis_s_tdata[i*AXIS_DW +: AXIS_DW];
                sel_keep = axis_s_tkeep[i*AXIS_KW +: AXIS_KW];
                sel_last = axis_s_tlast[i];
                acc = can_load & axis_s_tvalid[i];
            end
        end
        state_nx = acc ? (sel_last ? IDLE : PKT) : state;
    end
    // State register and source latch held for the length of a packet
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            src_q <= '0;
        end else begin
            state <= state_nx;
            if (acc) src_q <= eff;
        end
    end
    // Master output register: load on accept, drop valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            axis_m_tvalid <= 1'b0;
            axis_m_tlast <= 1'b0;
            axis_m_tdata <= '0;
            axis_m_tkeep <= '0;
        end else if (acc) begin
            axis_m_tvalid <= 1'b1;
            axis_m_tlast <= sel_last;
            axis_m_tdata <= sel_data;
            axis_m_tkeep <= sel_keep;
        end else if (axis_m_tready) begin
            axis_m_tvalid <= 1'b0;
        end
    end
`ifdef AURORA_TX_MUX_STAT_EN
    // Count frames delivered downstream
    always_ff @(posedge clk) begin
        if (rst) pkt_cnt <= '0;
        else if (axis_m_tvalid & axis_m_tready & axis_m_tlast) pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_aurora_axis_tx_mux.sv
// tb_aurora_axis_tx_mux: randomized and directed checks of the Aurora TX mux against a transaction-level model
module tb_aurora_axis_tx_mux;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] sel = 2'd0;
    logic [N-1:0] s_tready;
    logic [N*32-1:0] s_tdata = '0;
    logic [N*4-1:0] s_tkeep = '0;
    logic [N-1:0] s_tvalid = '0;
    logic [N-1:0] s_tlast = '0;
    logic m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic [3:0] m_tkeep;
    logic m_tvalid, m_tlast;
`ifdef AURORA_TX_MUX_STAT_EN
    logic [15:0] pkt_cnt;
`endif

    aurora_axis_tx_mux #(.ETHCOUNT(N), .SIM(1)) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .axis_s_tready(s_tready), .axis_s_tdata(s_tdata), .axis_s_tkeep(s_tkeep),
        .axis_s_tvalid(s_tvalid), .axis_s_tlast(s_tlast),
        .axis_m_tready(m_tready), .axis_m_tdata(m_tdata), .axis_m_tkeep(m_tkeep),
        .axis_m_tvalid(m_tvalid), .axis_m_tlast(m_tlast)
`ifdef AURORA_TX_MUX_STAT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // upstream frame generators
    int len[N], idx[N], fn[N], left[N], fixlen[N];
    logic [3:0] kk[N];
    bit rnd_valid = 0, rnd_mode = 0;
    int drop = 0;

    // reference model: pending output beat plus packet ownership
    bit mv = 0, ml = 0, in_pkt = 0;
    logic [31:0] md = '0;
    logic [3:0] mk = '0;
    int cur = 0, mcnt = 0;
    bit acc_f = 0;
    int acc_i = 0;
    bit chk_en = 0;

    logic [31:0] oq_d[$];
    bit oq_l[$];

    function automatic void new_frame(input int i);
        len[i] = fixlen[i] != 0 ? fixlen[i] : $urandom_range(32, 1);
        idx[i] = 0;
        fn[i]++;
        kk[i] = 4'($urandom_range(15, 1));
    endfunction

    task automatic model_step();
        int e;
        acc_f = 0;
        if (rst) begin
            mv = 0; ml = 0; md = '0; mk = '0; in_pkt = 0; cur = 0; mcnt = 0;
        end else begin
            if (mv && m_tready && ml) mcnt = (mcnt + 1) & 16'hFFFF;
            e = in_pkt ? cur : int'(sel);
            if (e < N && (!mv || m_tready) && s_tvalid[e]) begin
                md = s_tdata[e*32 +: 32];
                mk = s_tkeep[e*4 +: 4];
                ml = s_tlast[e];
                mv = 1;
                in_pkt = !ml;
                cur = e;
                acc_f = 1;
                acc_i = e;
            end else if (m_tready) begin
                mv = 0;
            end
        end
    endtask

    // upstream drivers and model advance, once per clock
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            for (int i = 0; i < N; i++) begin
                bit took;
                took = acc_f && acc_i == i;
                if (took) begin
                    idx[i]++;
                    if (idx[i] == len[i]) begin
                        left[i]--;
                        new_frame(i);
                    end
                end
                if (left[i] <= 0) s_tvalid[i] = 1'b0;
                else if (!(s_tvalid[i] && !took)) s_tvalid[i] = rnd_valid ? ($urandom_range(3) != 0) : 1'b1;
                s_tdata[i*32 +: 32] = {4'(i), 12'(fn[i]), 16'(idx[i])};
                s_tlast[i] = idx[i] == len[i] - 1;
                s_tkeep[i*4 +: 4] = s_tlast[i] ? kk[i] : 4'hF;
            end
            if (rnd_mode) begin
                if (drop > 0) begin
                    drop--;
                    m_tready = 1'b0;
                end else if ($urandom_range(63) == 0) begin
                    drop = 4;
                    m_tready = 1'b0;
                end else m_tready = $urandom_range(4) != 0;
                if ($urandom_range(15) == 0) sel = 2'($urandom_range(3));
            end
        end
    end

    // per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        int e;
        logic [3:0] et;
        if (chk_en) begin
            e = in_pkt ? cur : int'(sel);
            et = (!rst && e < N && (!mv || m_tready)) ? 4'(1 << e) : 4'b0;
            chk("cycle", {22'b0, s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata},
                {22'b0, et, mv, ml, mk, md});
`ifdef AURORA_TX_MUX_STAT_EN
            chk("pkt_cnt_cycle", {48'b0, pkt_cnt}, 64'(mcnt));
`endif
        end
        if (m_tvalid && m_tready) begin
            oq_d.push_back(m_tdata);
            oq_l.push_back(m_tlast);
        end
    end

    task automatic restart(input int n0, n1, n2, n3, input int f0, f1, f2, f3);
        rst = 1'b1;
        left[0] = n0; left[1] = n1; left[2] = n2; left[3] = n3;
        fixlen[0] = f0; fixlen[1] = f1; fixlen[2] = f2; fixlen[3] = f3;
        for (int i = 0; i < N; i++) begin
            fn[i] = 0;
            new_frame(i);
        end
        s_tvalid = '0;
        repeat (2) @(posedge clk);
        #2;
        oq_d.delete();
        oq_l.delete();
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nlast;
        int efn[N], eix[N];
        logic [31:0] held;
        for (int i = 0; i < N; i++) begin
            left[i] = 0; fixlen[i] = 0; fn[i] = 0; len[i] = 1; idx[i] = 0; kk[i] = 4'hF;
        end
        step();
        chk_en = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tready", {60'b0, s_tready}, 64'h0);
            chk("rst_mvalid", {63'b0, m_tvalid}, 64'h0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready_sel0", {60'b0, s_tready}, 64'h1);
        chk("idle_mvalid", {63'b0, m_tvalid}, 64'h0);

        // backpressure in the middle of a 16-beat frame
        step();
        restart(1, 0, 0, 0, 16, 0, 0, 0);
        for (int c = 0; c < 100 && oq_d.size() < 5; c++) step();
        chk("bp_started", 64'(oq_d.size() >= 5), 64'h1);
        m_tready = 1'b0;
        held = m_tdata;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_data", {32'b0, m_tdata}, {32'b0, held});
            chk("bp_hold_valid", {63'b0, m_tvalid}, 64'h1);
            chk("bp_s0_ready", {63'b0, s_tready[0]}, 64'h0);
            step();
        end
        m_tready = 1'b1;
        for (int c = 0; c < 100 && oq_d.size() < 16; c++) step();
        repeat (3) step();
        chk("bp_count", 64'(oq_d.size()), 64'd16);
        for (int k = 0; k < oq_d.size() && k < 16; k++) begin
            chk("bp_word", {32'b0, oq_d[k]}, {32'b0, 4'd0, 12'd1, 16'(k)});
            chk("bp_last", 64'(oq_l[k]), 64'(k == 15));
        end

        // sel change mid-frame takes effect only after tlast
        restart(1, 0, 1, 0, 8, 0, 4, 0);
        for (int c = 0; c < 100 && oq_d.size() < 3; c++) step();
        sel = 2'd2;
        for (int c = 0; c < 100 && oq_d.size() < 12; c++) step();
        repeat (3) step();
        chk("sw_count", 64'(oq_d.size()), 64'd12);
        for (int k = 0; k < oq_d.size() && k < 12; k++) begin
            chk("sw_word", {32'b0, oq_d[k]},
                {32'b0, (k < 8) ? {4'd0, 12'd1, 16'(k)} : {4'd2, 12'd1, 16'(k - 8)}});
            chk("sw_last", 64'(oq_l[k]), 64'(k == 7 || k == 11));
        end

        // single-beat frame keeps IDLE so the next cycle's sel is honoured
        sel = 2'd1;
        restart(0, 1, 0, 2, 0, 1, 0, 1);
        for (int c = 0; c < 50 && !(acc_f && acc_i == 1); c++) step();
        chk("sb_accepted", 64'(acc_f && acc_i == 1), 64'h1);
        sel = 2'd3;
        @(negedge clk);
        chk("sb_tready_sel3", {60'b0, s_tready}, 64'h8);
        for (int c = 0; c < 50 && oq_d.size() < 3; c++) step();
        repeat (3) step();
        chk("sb_count", 64'(oq_d.size()), 64'd3);
        for (int k = 0; k < oq_d.size() && k < 3; k++) begin
            chk("sb_src", 64'(oq_d[k][31:28]), (k == 0) ? 64'd1 : 64'd3);
            chk("sb_last", 64'(oq_l[k]), 64'h1);
        end

        // randomized traffic, valid gaps, backpressure and sel changes
        sel = 2'd0;
        restart(12, 12, 12, 12, 0, 0, 0, 0);
        rnd_valid = 1;
        rnd_mode = 1;
        for (int c = 0; c < 30000 && (left[0] + left[1] + left[2] + left[3]) > 0; c++) step();
        chk("rnd_done", 64'(left[0] + left[1] + left[2] + left[3]), 64'd0);
        rnd_mode = 0;
        rnd_valid = 0;
        m_tready = 1'b1;
        repeat (4) step();
        nlast = 0;
        for (int i = 0; i < N; i++) begin
            efn[i] = 1;
            eix[i] = 0;
        end
        foreach (oq_d[k]) begin
            int s;
            s = int'(oq_d[k][31:28]);
            if (s < N) begin
                chk("rnd_order", {36'b0, oq_d[k][27:0]}, {36'b0, 12'(efn[s]), 16'(eix[s])});
                eix[s]++;
                if (oq_l[k]) begin
                    efn[s]++;
                    eix[s] = 0;
                    nlast++;
                end
            end else chk("rnd_src", 64'(s), 64'd0);
        end
        chk("rnd_frames", 64'(nlast), 64'd48);

`ifdef AURORA_TX_MUX_STAT_EN
        restart(32, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5000 && left[0] > 0; c++) step();
        repeat (4) step();
        chk("pkt_cnt_32", {48'b0, pkt_cnt}, 64'd32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
